// File: rtl/cnn_job_seq.sv
// Destination-domain job sequencer: turns one go pulse into NTILE tile launches and one done pulse.
// Optional tile watchdog is compiled in with `define JOB_WDOG_EN (adds timeout_o).
module cnn_job_seq #(
    parameter int NTILE_W = 8,
    parameter int WDOG_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go_i,
    input  logic [NTILE_W-1:0] cfg_ntile_i,
    output logic               tile_go_o,
    output logic [NTILE_W-1:0] tile_idx_o,
    input  logic               tile_done_i,
    output logic               done_o,
    output logic               busy_o,
    output logic               overrun_o,
    output logic               spurious_o,
`ifdef JOB_WDOG_EN
    output logic               timeout_o,
`endif
    output logic [1:0]         state_o
);

    // Handshake: go_i, tile_go_o, tile_done_i and done_o are all single-cycle
    // pulses with no back-pressure; the producer never waits for an ack, so a go
    // that cannot be queued (one already pending) is dropped and flagged.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t             state_r;
    logic [NTILE_W-1:0] ntile_r;
    logic [NTILE_W-1:0] cnt_r;
    logic               pending_r;
    logic               start_job;

`ifdef JOB_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = {{(WDOG_W-1){1'b1}}, 1'b0};
    logic [WDOG_W-1:0] wdog_r;
`endif

    assign state_o    = state_r;
    assign tile_idx_o = cnt_r;

    // A job starts from IDLE on go, or straight out of DONE when a go is queued
    // or arrives in the DONE cycle itself.
    always_comb begin
        start_job = 1'b0;
        if (state_r == IDLE) begin
            start_job = go_i;
        end else if (state_r == DONE) begin
            start_job = go_i | pending_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            ntile_r    <= '0;
            cnt_r      <= '0;
            pending_r  <= 1'b0;
            tile_go_o  <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
            overrun_o  <= 1'b0;
            spurious_o <= 1'b0;
`ifdef JOB_WDOG_EN
            wdog_r     <= '0;
            timeout_o  <= 1'b0;
`endif
        end else begin
            tile_go_o <= 1'b0;
            done_o    <= 1'b0;

            if (start_job) begin
                ntile_r <= cfg_ntile_i;
                cnt_r   <= '0;
                busy_o  <= 1'b1;
                if (cfg_ntile_i == '0) begin
                    state_r <= DONE;
                    done_o  <= 1'b1;
                end else begin
                    state_r   <= LAUNCH;
                    tile_go_o <= 1'b1;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    LAUNCH: begin
                        state_r <= WAIT;
`ifdef JOB_WDOG_EN
                        wdog_r  <= '0;
`endif
                    end
                    WAIT: begin
                        if (tile_done_i) begin
                            if (cnt_r == ntile_r - NTILE_W'(1)) begin
                                state_r <= DONE;
                                done_o  <= 1'b1;
                            end else begin
                                cnt_r     <= cnt_r + NTILE_W'(1);
                                state_r   <= LAUNCH;
                                tile_go_o <= 1'b1;
                            end
                        end
`ifdef JOB_WDOG_EN
                        // Counter reaches all-ones on this edge: abandon the remaining tiles.
                        else if (wdog_r == WDOG_LAST) begin
                            wdog_r    <= wdog_r + WDOG_W'(1);
                            state_r   <= DONE;
                            done_o    <= 1'b1;
                            timeout_o <= 1'b1;
                        end else begin
                            wdog_r <= wdog_r + WDOG_W'(1);
                        end
`endif
                    end
                    DONE: begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_o  <= 1'b0;
                    end
                endcase
            end

            // Go outside IDLE: queue one, flag the rest. A go in DONE with nothing
            // queued was already consumed by start_job.
            if (go_i && state_r != IDLE) begin
                if (pending_r) begin
                    overrun_o <= 1'b1;
                end else if (state_r != DONE) begin
                    pending_r <= 1'b1;
                end
            end
            if (state_r == DONE && pending_r) begin
                pending_r <= 1'b0;
            end

            if (tile_done_i && state_r != WAIT) begin
                spurious_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cnn_job_seq.sv
// Directed bench for cnn_job_seq: expected tile/done events are queued per job and
// checked in order by a monitor as the DUT emits them.
module tb_cnn_job_seq;

    localparam int NTILE_W = 8;
    localparam int WDOG_W  = 4;
    localparam int EW      = NTILE_W + 1;

    logic               clk;
    logic               rst;
    logic               go_i;
    logic [NTILE_W-1:0] cfg_ntile_i;
    logic               tile_go_o;
    logic [NTILE_W-1:0] tile_idx_o;
    logic               tile_done_i;
    logic               done_o;
    logic               busy_o;
    logic               overrun_o;
    logic               spurious_o;
    logic [1:0]         state_o;
`ifdef JOB_WDOG_EN
    logic               timeout_o;
`endif

    logic    resp_done;
    logic    manual_done;
    logic    resp_en;
    int      resp_delay;
    int      resp_timer;
    int      cyc;
    int      last_tdone_cyc;
    int      done_cnt;
    int      tests;
    int      fails;
    logic [EW-1:0] exp_q[$];

    assign tile_done_i = resp_done | manual_done;

    cnn_job_seq #(
        .NTILE_W(NTILE_W),
        .WDOG_W (WDOG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .go_i       (go_i),
        .cfg_ntile_i(cfg_ntile_i),
        .tile_go_o  (tile_go_o),
        .tile_idx_o (tile_idx_o),
        .tile_done_i(tile_done_i),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .spurious_o (spurious_o),
`ifdef JOB_WDOG_EN
        .timeout_o  (timeout_o),
`endif
        .state_o    (state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Compute-engine model: answers each tile_go_o with tile_done_i after resp_delay cycles.
    always @(negedge clk) begin
        if (rst) begin
            resp_timer = 0;
            resp_done  = 1'b0;
        end else begin
            resp_done = 1'b0;
            if (resp_timer != 0) begin
                resp_timer = resp_timer - 1;
                if (resp_timer == 0) begin
                    resp_done      = 1'b1;
                    last_tdone_cyc = cyc;
                end
            end
            if (tile_go_o && resp_en) resp_timer = resp_delay;
        end
    end

    // Scoreboard monitor
    task automatic sb_event(input string name, input logic [EW-1:0] act);
        logic [EW-1:0] e;
        tests = tests + 1;
        if (exp_q.size() == 0) begin
            fails = fails + 1;
            $display("FAIL sb_%s: unexpected event 0x%0h, none expected", name, act);
        end else begin
            e = exp_q.pop_front();
            if (e != act) begin
                fails = fails + 1;
                $display("FAIL sb_%s: got 0x%0h expected 0x%0h", name, act, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (tile_go_o) sb_event("tile_go", {1'b0, tile_idx_o});
            if (done_o) begin
                done_cnt = done_cnt + 1;
                sb_event("done", {1'b1, {NTILE_W{1'b0}}});
            end
        end
    end

    // Driver tasks
    task automatic push_job(input int ntile);
        for (int i = 0; i < ntile; i++) exp_q.push_back({1'b0, NTILE_W'(i)});
        exp_q.push_back({1'b1, {NTILE_W{1'b0}}});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        go_i = 1'b0;
        manual_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_go(input int ntile);
        go_i        = 1'b1;
        cfg_ntile_i = NTILE_W'(ntile);
        @(negedge clk);
        go_i        = 1'b0;
        cfg_ntile_i = 8'hA5;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_o && n < max_cyc);
        if (!done_o) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic wait_tile(input string name, input int idx, input int max_cyc);
        int n = 0;
        while (!(tile_go_o && tile_idx_o == NTILE_W'(idx)) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!(tile_go_o && tile_idx_o == NTILE_W'(idx))) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int t0;
        tests = 0; fails = 0; cyc = 0; done_cnt = 0; last_tdone_cyc = 0;
        rst = 1'b1; go_i = 1'b0; cfg_ntile_i = '0; manual_done = 1'b0;
        resp_en = 1'b1; resp_delay = 4;
        do_reset();

        // Reset state
        check("rst_busy", busy_o, 0);
        check("rst_tile_go", tile_go_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_spurious", spurious_o, 0);
        check("rst_idx", tile_idx_o, 0);
        check("rst_state", state_o, 0);

        // Three-tile job, cfg changed after acceptance
        push_job(3);
        pulse_go(3);
        check("j3_busy_t1", busy_o, 1);
        check("j3_tile_go_t1", tile_go_o, 1);
        wait_done("j3", 100);
        check("j3_done_lat", cyc - last_tdone_cyc, 1);
        check("j3_busy_done", busy_o, 1);
        @(negedge clk);
        check("j3_busy_after", busy_o, 0);
        check("j3_done_after", done_o, 0);

        // Zero-tile job
        push_job(0);
        pulse_go(0);
        check("j0_done", done_o, 1);
        check("j0_busy", busy_o, 1);
        check("j0_tile_go", tile_go_o, 0);
        @(negedge clk);
        check("j0_busy_after", busy_o, 0);
        check("j0_done_after", done_o, 0);

        // Queued go and overrun; pending job samples cfg=1 at the DONE edge
        done_cnt = 0;
        push_job(2);
        push_job(1);
        pulse_go(2);
        go_i = 1'b1; cfg_ntile_i = 8'd1;
        @(negedge clk);
        go_i = 1'b0;
        wait_tile("ov_idx1", 1, 50);
        go_i = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
        wait_done("ov_first", 100);
        @(negedge clk);
        check("ov_relaunch", tile_go_o, 1);
        wait_done("ov_second", 100);
        @(negedge clk);
        check("ov_busy_after", busy_o, 0);
        check("ov_flag", overrun_o, 1);
        check("ov_spurious", spurious_o, 0);
        check("ov_done_cnt", done_cnt, 2);

        // Spurious completion while IDLE
        do_reset();
        check("sp_clear", overrun_o, 0);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        check("sp_idle", spurious_o, 1);
        check("sp_idle_state", state_o, 0);

        // Spurious completion in the LAUNCH cycle
        do_reset();
        push_job(2);
        pulse_go(2);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        check("sp_launch", spurious_o, 1);
        check("sp_launch_idx", tile_idx_o, 0);
        check("sp_launch_state", state_o, 2);
        wait_done("sp_job", 100);
        @(negedge clk);
        check("sp_job_busy_after", busy_o, 0);

        // Reset in WAIT at tile 1 of 4, then a clean one-tile job
        push_job(4);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        pulse_go(4);
        wait_tile("rw_idx1", 1, 50);
        @(negedge clk);
        check("rw_wait_state", state_o, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_state", state_o, 0);
        check("rw_busy", busy_o, 0);
        check("rw_idx", tile_idx_o, 0);
        check("rw_tile_go", tile_go_o, 0);
        check("rw_done", done_o, 0);
        check("rw_flags", {overrun_o, spurious_o}, 0);
        push_job(1);
        pulse_go(1);
        wait_done("rw_job", 100);
        @(negedge clk);
        check("rw_busy_after", busy_o, 0);

`ifdef JOB_WDOG_EN
        // Watchdog expiry: no completions
        do_reset();
        resp_en = 1'b0;
        exp_q.push_back({1'b0, {NTILE_W{1'b0}}});
        exp_q.push_back({1'b1, {NTILE_W{1'b0}}});
        pulse_go(2);
        t0 = cyc;
        wait_done("wd", 100);
        check("wd_latency", cyc - t0, 16);
        check("wd_timeout", timeout_o, 1);
        repeat (3) @(negedge clk);
        check("wd_idle", state_o, 0);
`else
        t0 = 0;
`endif

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
